alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (4-bit opcode, 32-bit operands) between two requesters, e.g. main EX stage (req0) and a branch/address helper (req1).
- Round-robin arbitration, valid/ready handshakes on request and response sides.
- Operands and result are registered, so the ALU sits between two flop stages.
- Sequenced by a 3-state FSM.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- OPCODE_LENGTH, 4, ALU operation code width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready.
- req0_src_a / req1_src_a  in  DATA_WIDTH  operand A.
- req0_src_b / req1_src_b  in  DATA_WIDTH  operand B.
- req0_op / req1_op  in  OPCODE_LENGTH  ALU operation code.
- rsp0_valid / rsp1_valid  out  1  result available for that requester.
- rsp0_ready / rsp1_ready  in  1  requester consumes result.
- rsp_result  out  DATA_WIDTH  registered result, shared; valid only with rspN_valid.
- alu_src_a / alu_src_b  out  DATA_WIDTH  to ALU SrcA/SrcB.
- alu_op  out  OPCODE_LENGTH  to ALU Operation.
- alu_result  in  DATA_WIDTH  from ALU ALUResult (combinational).

Behaviour:
- Reset values (async on rst_n low):
  - state=IDLE.
  - All ready/valid outputs 0.
  - rsp_result=0; alu_src_a/b=0; alu_op=0.
  - owner=0; last_grant=1, so req0 wins the first tie.
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - reqN_ready = grant for N, combinational from valids and last_grant.
  - Grant rule: only one valid → that one; both valid → the one != last_grant; none → no grant, both ready 0.
  - On handshake: capture src_a, src_b, op into issue regs; owner=N; last_grant=N; → EXEC.
- EXEC (1 cycle):
  - alu_src_a/b/alu_op driven from issue regs.
  - Both req ready 0.
  - At the clock edge, rsp_result ← alu_result; → HOLD.
- HOLD:
  - rsp<owner>_valid=1; the other rsp_valid=0; both req ready 0.
  - When rsp<owner>_ready=1, handshake completes that edge → IDLE. rsp_valid drops next cycle.
  - rsp_ready of the non-owner is ignored.
- Outside EXEC: alu_src_a/b and alu_op forced to 0 (ALU default path, result 0).
- Latency:
  - Accept at edge T.
  - rsp_valid high in the cycle after edge T+1.
  - Minimum issue interval 3 cycles (IDLE→EXEC→HOLD→IDLE); the next accept is earliest in the IDLE cycle after the response handshake.
- Protocol:
  - Once reqN_valid is high it stays high with stable payload until accepted.
  - rspN_valid stays high with stable rsp_result until rspN_ready.
- Opcode passes through unchecked; undefined codes yield whatever the ALU returns (0).
- Width: no arithmetic in this block; all data paths are DATA_WIDTH exact, no truncation.
- Simultaneous events:
  - rsp_ready already high when HOLD is entered: exactly one HOLD cycle.
  - A new request arriving during EXEC/HOLD waits and is not lost.
- Reset mid-operation: the in-flight op is dropped, no response is produced, and the FSM returns to IDLE.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined, adds these outputs, all reset to 0:
  - grant0_cnt, grant1_cnt (32-bit): increment on each accepted request of that requester.
  - conflict_cnt (32-bit): increments on every IDLE grant cycle where both valids are high.
  - All counters wrap modulo 2^32.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Single op: req0 op=1, A=5, B=7, rsp0_ready=1 → req0_ready in IDLE; alu_op=1 during EXEC; rsp0_valid with rsp_result=12 two cycles after accept; rsp1_valid stays 0.
- Tie: both valid in same cycle after reset; req0 op=2 (10−3), req1 op=3 (0xF0^0x0F) → req0 served first, result 7; then req1, result 0xFF.
- Fairness: both requesters held valid for 6 ops → grants alternate 0,1,0,1,0,1.
- Backpressure: rsp1_ready low for 4 cycles → rsp1_valid and rsp_result=value held stable; req0 waits with req0_ready=0 until the handshake, then is accepted.
- Reset mid-op: assert rst_n=0 during EXEC → all outputs 0 immediately; after release no rsp_valid appears for the dropped op.
- Stats (ALU_ARB_STATS_EN): 3 ties + 2 solo req0 → grant0_cnt=5, grant1_cnt=3, conflict_cnt=3.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters,
// with registered operands and result. Define ALU_ARB_STATS_EN for grant/conflict counters.
module alu_share_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_WIDTH-1:0]    req0_src_a,
    input  logic [DATA_WIDTH-1:0]    req0_src_b,
    input  logic [OPCODE_LENGTH-1:0] req0_op,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_WIDTH-1:0]    req1_src_a,
    input  logic [DATA_WIDTH-1:0]    req1_src_b,
    input  logic [OPCODE_LENGTH-1:0] req1_op,
    output logic                     rsp0_valid,
    input  logic                     rsp0_ready,
    output logic                     rsp1_valid,
    input  logic                     rsp1_ready,
    output logic [DATA_WIDTH-1:0]    rsp_result,
    output logic [DATA_WIDTH-1:0]    alu_src_a,
    output logic [DATA_WIDTH-1:0]    alu_src_b,
    output logic [OPCODE_LENGTH-1:0] alu_op,
`ifdef ALU_ARB_STATS_EN
    output logic [31:0]              grant0_cnt,
    output logic [31:0]              grant1_cnt,
    output logic [31:0]              conflict_cnt,
`endif
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic                       owner_q, owner_d;
    logic                       last_grant_q, last_grant_d;
    logic                       rsp0_valid_q, rsp0_valid_d;
    logic                       rsp1_valid_q, rsp1_valid_d;
    logic [DATA_WIDTH-1:0]      rsp_result_q, rsp_result_d;
    logic [DATA_WIDTH-1:0]      issue_a_q, issue_a_d;
    logic [DATA_WIDTH-1:0]      issue_b_q, issue_b_d;
    logic [OPCODE_LENGTH-1:0]   issue_op_q, issue_op_d;

    logic                       grant0_s;
    logic                       grant1_s;
    logic                       both_valid_s;
    logic                       rsp_hs_s;

`ifdef ALU_ARB_STATS_EN
    logic [31:0]                grant0_cnt_q, grant0_cnt_d;
    logic [31:0]                grant1_cnt_q, grant1_cnt_d;
    logic [31:0]                conflict_cnt_q, conflict_cnt_d;
`endif

    assign both_valid_s = req0_valid & req1_valid;
    assign rsp_hs_s     = (state_q == ST_HOLD) & (owner_q ? rsp1_ready : rsp0_ready);

    // Round-robin grant; offered only while idle and out of reset so ready is 0 under reset.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst_n && (state_q == ST_IDLE)) begin
            if (both_valid_s) begin
                if (last_grant_q) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (req0_valid) begin
                grant0_s = 1'b1;
            end else if (req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Next-state and datapath register update.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp_result_d = rsp_result_q;
        issue_a_d    = issue_a_q;
        issue_b_d    = issue_b_q;
        issue_op_d   = issue_op_q;
`ifdef ALU_ARB_STATS_EN
        grant0_cnt_d   = grant0_cnt_q;
        grant1_cnt_d   = grant1_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant0_s || grant1_s) begin
                    // Issue registers feed the ALU directly, so they are only non-zero during EXEC.
                    issue_a_d    = grant1_s ? req1_src_a : req0_src_a;
                    issue_b_d    = grant1_s ? req1_src_b : req0_src_b;
                    issue_op_d   = grant1_s ? req1_op    : req0_op;
                    owner_d      = grant1_s;
                    last_grant_d = grant1_s;
                    state_d      = ST_EXEC;
`ifdef ALU_ARB_STATS_EN
                    if (grant1_s) begin
                        grant1_cnt_d = grant1_cnt_q + 32'd1;
                    end else begin
                        grant0_cnt_d = grant0_cnt_q + 32'd1;
                    end
                    if (both_valid_s) begin
                        conflict_cnt_d = conflict_cnt_q + 32'd1;
                    end else begin
                        conflict_cnt_d = conflict_cnt_q;
                    end
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                rsp_result_d = alu_result;
                issue_a_d    = {DATA_WIDTH{1'b0}};
                issue_b_d    = {DATA_WIDTH{1'b0}};
                issue_op_d   = {OPCODE_LENGTH{1'b0}};
                rsp0_valid_d = ~owner_q;
                rsp1_valid_d = owner_q;
                state_d      = ST_HOLD;
            end
            ST_HOLD: begin
                if (rsp_hs_s) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                rsp0_valid_d = 1'b0;
                rsp1_valid_d = 1'b0;
                issue_a_d    = {DATA_WIDTH{1'b0}};
                issue_b_d    = {DATA_WIDTH{1'b0}};
                issue_op_d   = {OPCODE_LENGTH{1'b0}};
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_result_q <= {DATA_WIDTH{1'b0}};
            issue_a_q    <= {DATA_WIDTH{1'b0}};
            issue_b_q    <= {DATA_WIDTH{1'b0}};
            issue_op_q   <= {OPCODE_LENGTH{1'b0}};
`ifdef ALU_ARB_STATS_EN
            grant0_cnt_q   <= 32'd0;
            grant1_cnt_q   <= 32'd0;
            conflict_cnt_q <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp_result_q <= rsp_result_d;
            issue_a_q    <= issue_a_d;
            issue_b_q    <= issue_b_d;
            issue_op_q   <= issue_op_d;
`ifdef ALU_ARB_STATS_EN
            grant0_cnt_q   <= grant0_cnt_d;
            grant1_cnt_q   <= grant1_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
`endif
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_result = rsp_result_q;
    assign alu_src_a  = issue_a_q;
    assign alu_src_b  = issue_b_q;
    assign alu_op     = issue_op_q;
`ifdef ALU_ARB_STATS_EN
    assign grant0_cnt   = grant0_cnt_q;
    assign grant1_cnt   = grant1_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
